fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Drains the synchronous FIFO and presents its words on a valid/ready output stream. It sits on the FIFO read side, owning `rd_en`, and tolerates the FIFO's one-cycle registered read latency with a 2-entry output buffer. Sustains one word per cycle under continuous `m_ready`, never reads an empty FIFO and never drops or reorders a word.

## Interface
- `DATA_WIDTH`, 8: word width; must equal the FIFO's `DATA_WIDTH`.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  permits new FIFO reads while high.
- `fifo_rd_en`  out  1  FIFO read strobe; connects to FIFO `rd_en`.
- `fifo_dout`  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted `fifo_rd_en`.
- `fifo_empty`  in  1  FIFO empty flag.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word.
- `m_ready`  in  1  downstream accept.
- `words_out`  out  CNT_WIDTH  count of completed output handshakes.
- `busy`  out  1  high when state is not IDLE.

## Operation
- `inflight` (1 bit): set on any edge where `fifo_rd_en`=1, else cleared. When set, `fifo_dout` is written into the buffer tail at that edge.
- Buffer: 2 entries, `occ` 0..2. Head drives `m_data`; `m_valid` = (`occ`>0).
- `pop` = `m_valid & m_ready`.
- `fifo_rd_en` = `enable & !fifo_empty & (state==RUN) & (occ + inflight - pop < 2)`. This is combinational from `m_ready`, which is intentional for full throughput.
- Same-edge push and pop leaves `occ` unchanged. Pop removes the head; push appends at the tail. Order is strictly FIFO.
- `words_out` increments by 1 on each `pop` and wraps modulo 2^CNT_WIDTH.
- State machine:
  - IDLE -> RUN when `enable`=1.
  - RUN -> DRAIN when `enable`=0 and (`inflight` or `occ`>0); RUN -> IDLE when `enable`=0 and nothing is pending.
  - DRAIN: issues no reads. Returns to RUN if `enable`=1. Goes to IDLE once `inflight`=0 and `occ`=0.
- `enable` never aborts a pending word: in-flight data is captured and buffered words are still offered.
- `m_valid` and `m_data` stay stable until `pop`. `m_valid` never falls without a handshake, except on `rst`.

## Timing
- Reset values (all take effect at the edge where `rst`=1):
  - `fifo_rd_en`=0 while `rst`=1.
  - `m_valid`=0, `m_data`=0, `words_out`=0, `busy`=0.
  - `occ`=0, `inflight`=0, state=IDLE.
- Reset mid-operation discards buffered words. A FIFO word whose read was issued the cycle before `rst` is not captured, so the FIFO and reader must be reset together.
- Read latency: `fifo_rd_en` high in cycle 0 -> `fifo_dout` valid in cycle 1 -> captured at end of cycle 1 -> `m_valid`=1 in cycle 2.
- Steady-state throughput with `m_ready`=1 and a non-empty FIFO is 1 word/cycle (`occ`=1, `inflight`=1).
- `m_ready`=0 stops reads once `occ + inflight` = 2. No overflow is possible.
- When `fifo_empty` rises, reads stop that cycle; buffered and in-flight words still drain.

## Structure
- Package `fifo_rd_pkg`:
  - state enum `rd_state_t` {IDLE, RUN, DRAIN};
  - `BUF_ENTRIES`=2;
  - default width constants.
- Sub-module `stream_skid_buf`: the 2-entry buffer with push/pop/occ. The top level holds the state machine, `inflight`, read-issue logic and counter.

## Test plan
- Reset, then write 8'hAA to the FIFO and set `enable`=1, `m_ready`=1 -> `m_data`=8'hAA with `m_valid` 2 cycles after `fifo_rd_en`; `words_out`=1; returns to IDLE after `enable`=0.
- Preload 16 words 10..25, hold `m_ready`=1 -> 16 consecutive handshakes with data 10..25 in order, no bubbles after the first; `fifo_empty`=1; `fifo_rd_en` is never asserted while `fifo_empty`=1.
- Preload 16 words, hold `m_ready`=0 for 20 cycles -> exactly 2 reads issued, `m_valid`=1, `m_data` stable; releasing `m_ready` delivers all 16 in order.
- Drop `enable` mid-stream with a read in flight -> state goes to DRAIN, the in-flight and buffered words are delivered, then IDLE with `busy`=0; remaining FIFO words are untouched.
- Toggle `m_ready` randomly for 200 words with FIFO writes interleaved -> output sequence equals the write sequence and `words_out`=200.
- Assert `rst` for 1 cycle with `occ`=2 -> next cycle `m_valid`=0 and `words_out`=0; reads resume correctly after `enable`.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } rd_state_t;

    localparam int unsigned BUF_ENTRIES       = 2;
    localparam int unsigned OCC_WIDTH         = $clog2(BUF_ENTRIES + 1);
    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam int unsigned DEF_CNT_WIDTH     = 16;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer: push appends at the tail, pop removes the head.
module stream_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [OCC_WIDTH-1:0]  occ_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [OCC_WIDTH-1:0]  occ_q, occ_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (occ_q == '0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                occ_d = occ_q + OCC_WIDTH'(1);
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = occ_q - OCC_WIDTH'(1);
            end
            2'b11: begin
                // Occupancy unchanged; the new word lands behind whatever survives the pop.
                if (occ_q == OCC_WIDTH'(1)) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read synchronous FIFO onto a valid/ready stream at one word per cycle.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_dout_i,
    input  logic                  fifo_empty_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic [CNT_WIDTH-1:0]  words_out_o,
    output logic                  busy_o
);

    localparam int unsigned PW = OCC_WIDTH + 1;

    rd_state_t             state_q, state_d;
    logic                  inflight_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [OCC_WIDTH-1:0]  occ;
    logic                  pop;
    logic                  pending;
    logic [PW-1:0]         committed;
    logic                  room;

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i (fifo_dout_i),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (m_data_o)
    );

    assign m_valid_o = (occ != '0);
    assign pop       = m_valid_o & m_ready_i;
    assign pending   = inflight_q | m_valid_o;

    // Slots already claimed after this cycle's pop; pop implies occ >= 1, so no underflow.
    assign committed = {1'b0, occ} + PW'(inflight_q) - PW'(pop);
    assign room      = committed < PW'(BUF_ENTRIES);

    assign fifo_rd_en_o = enable_i & ~fifo_empty_i & (state_q == StRun) & room & ~rst_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_WIDTH'(pop);
        unique case (state_q)
            StIdle: begin
                if (enable_i) state_d = StRun;
            end
            StRun: begin
                if (!enable_i) state_d = pending ? StDrain : StIdle;
            end
            StDrain: begin
                if (enable_i) begin
                    state_d = StRun;
                end else if (!pending) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_rd_en_o;
            cnt_q      <= cnt_d;
        end
    end

    assign words_out_o = cnt_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, scoreboard monitor, scenario table, corner sequences.
module tb_fifo_stream_reader;
    import fifo_rd_pkg::*;

    logic        clk = 1'b0;
    logic        rst, enable, fifo_rd_en, fifo_empty, m_valid, m_ready, busy;
    logic [7:0]  fifo_dout = 8'h00;
    logic [7:0]  m_data;
    logic [15:0] words_out;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (enable),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_dout_i  (fifo_dout),
        .fifo_empty_i (fifo_empty),
        .m_valid_o    (m_valid),
        .m_data_o     (m_data),
        .m_ready_i    (m_ready),
        .words_out_o  (words_out),
        .busy_o       (busy)
    );

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int fifo_cnt = 0, rd_cnt = 0, underflow = 0, cyc = 0;
    int compared = 0, mismatched = 0;
    int hs_total = 0, hs_first = -1, hs_last = -1, exp_words = 0;
    logic       hold_q = 1'b0;
    logic [7:0] hold_data = 8'h00;

    assign fifo_empty = (fifo_cnt == 0);

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        fifo_cnt++;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 3000; c++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check(name, exp_q.size(), 0);
    endtask

    task automatic wait_rd(input string name);
        bit seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (fifo_rd_en) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, seen, 1);
    endtask

    // Registered-read FIFO model.
    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en) begin
            if (fifo_cnt == 0) begin
                underflow++;
            end else begin
                fifo_dout <= fifo_q.pop_front();
                fifo_cnt--;
                rd_cnt++;
            end
        end
    end

    // Output monitor: stream stability and in-order scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, hold_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", 1, 0);
                else check("data", m_data, exp_q.pop_front());
                hs_total++;
                exp_words = (exp_words + 1) % 65536;
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
            end
            hold_q    = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    typedef struct {
        int n;
        int pct;
        bit inter;
        int base;
        int exp_words;
    } scn_t;

    scn_t tbl[4];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, hs0, written;

        tbl[0] = '{n: 16,  pct: 100, inter: 1'b0, base: 10,  exp_words: 16};
        tbl[1] = '{n: 12,  pct: 40,  inter: 1'b0, base: 50,  exp_words: 28};
        tbl[2] = '{n: 200, pct: 50,  inter: 1'b1, base: 0,   exp_words: 228};
        tbl[3] = '{n: 7,   pct: 100, inter: 1'b1, base: 200, exp_words: 235};

        rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        tick(3);
        check("rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        tick();
        check("reset_valid", m_valid, 0);
        check("reset_data", m_data, 0);
        check("reset_words", words_out, 0);
        check("reset_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            hs0 = hs_total; hs_first = -1;
            written = tbl[i].inter ? 0 : tbl[i].n;
            if (!tbl[i].inter) for (int k = 0; k < tbl[i].n; k++) push_word(8'(tbl[i].base + k));
            enable = 1'b1;
            for (int c = 0; c < 5000; c++) begin
                m_ready = (int'($urandom_range(0, 99)) < tbl[i].pct);
                if (tbl[i].inter && written < tbl[i].n && $urandom_range(0, 1) == 1) begin
                    push_word(8'(tbl[i].base + written));
                    written++;
                end
                tick();
                if (written == tbl[i].n && exp_q.size() == 0) break;
            end
            check("scn_done", (written == tbl[i].n) && (exp_q.size() == 0), 1);
            check("scn_delivered", hs_total - hs0, tbl[i].n);
            check("scn_words_out", words_out, tbl[i].exp_words);
            if (tbl[i].pct == 100 && !tbl[i].inter) check("scn_no_bubble", hs_last - hs_first,
                                                         tbl[i].n - 1);
            check("scn_fifo_empty", fifo_empty, 1);
            enable = 1'b0; m_ready = 1'b0;
            tick(4);
            check("scn_idle", busy, 0);
        end

        // Read latency: rd_en in cycle 0, m_valid in cycle 2.
        push_word(8'hAA);
        m_ready = 1'b1; enable = 1'b1;
        wait_rd("lat_rd_seen");
        @(negedge clk);
        check("lat_valid_c1", m_valid, 0);
        @(negedge clk);
        check("lat_valid_c2", m_valid, 1);
        check("lat_data", m_data, 8'hAA);
        tick();
        check("lat_words", words_out, 236);
        enable = 1'b0;
        tick(3);
        check("lat_idle", busy, 0);

        // Backpressure: only two reads while m_ready is low.
        m_ready = 1'b0;
        rd0 = rd_cnt; hs0 = hs_total;
        for (int k = 0; k < 16; k++) push_word(8'(100 + k));
        enable = 1'b1;
        tick(20);
        check("bp_reads", rd_cnt - rd0, 2);
        check("bp_valid", m_valid, 1);
        check("bp_data", m_data, 100);
        m_ready = 1'b1;
        drain("bp_drain");
        check("bp_delivered", hs_total - hs0, 16);
        check("bp_words", words_out, exp_words);
        enable = 1'b0;
        tick(3);

        // Drop enable with a read in flight.
        rd0 = rd_cnt;
        for (int k = 0; k < 8; k++) push_word(8'(150 + k));
        enable = 1'b1;
        wait_rd("drain_rd_seen");
        tick();
        enable = 1'b0;
        tick();
        check("drain_state", dut.state_q, StDrain);
        for (int c = 0; c < 40; c++) begin
            if (!busy) break;
            tick();
        end
        check("drain_idle", busy, 0);
        check("drain_reads", rd_cnt - rd0, 1);
        check("drain_fifo_left", fifo_cnt, 7);
        check("drain_pending", exp_q.size(), 7);
        enable = 1'b1;
        drain("drain_rest");
        enable = 1'b0;
        tick(3);

        // Reset with a full buffer.
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) push_word(8'(200 + k));
        enable = 1'b1;
        tick(8);
        check("rst_occ", dut.u_buf.occ_q, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fifo_q.delete(); exp_q.delete();
        fifo_cnt = 0; exp_words = 0;
        check("rst_mid_valid", m_valid, 0);
        check("rst_mid_words", words_out, 0);
        check("rst_mid_busy", busy, 0);
        for (int k = 0; k < 3; k++) push_word(8'(230 + k));
        m_ready = 1'b1;
        drain("rst_resume");
        check("rst_resume_words", words_out, 3);
        enable = 1'b0;
        tick(3);

        check("underflow", underflow, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
